// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled 8N1 UART receiver with majority vote, false-start rejection and framing-error detection
module uart_rx_os #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state;
  logic [1:0] sync;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [2:0] smp;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic rxs, tick, bit_end, stop_pt, maj, maj_stop;
  assign rxs      = sync[1];
  assign tick     = tcnt == TW'(DIV - 1);
  assign bit_end  = tick && scnt == SW'(OVERSAMPLE - 1);
  assign stop_pt  = tick && scnt == SW'(OVERSAMPLE / 2 + 1);
  assign maj      = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign maj_stop = (smp[0] & smp[1]) | ((smp[0] | smp[1]) & rxs);
  assign rx_busy  = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sync      <= 2'b11;
      tcnt      <= '0;
      scnt      <= '0;
      smp       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], RXD};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      tcnt      <= tick ? '0 : tcnt + 1'b1;
      if (tick) scnt <= (scnt == SW'(OVERSAMPLE - 1)) ? '0 : scnt + 1'b1;
      if (tick && scnt == SW'(OVERSAMPLE / 2 - 1)) smp[0] <= rxs;
      if (tick && scnt == SW'(OVERSAMPLE / 2)) smp[1] <= rxs;
      if (tick && scnt == SW'(OVERSAMPLE / 2 + 1)) smp[2] <= rxs;
      case (state)
        IDLE: if (!rxs) begin
          state <= START;
          tcnt  <= '0;
          scnt  <= '0;
        end
        START: if (bit_end) begin
          state <= maj ? IDLE : DATA;
          idx   <= '0;
        end
        DATA: if (bit_end) begin
          shreg[idx] <= maj;
          idx        <= idx + 1'b1;
          if (idx == 3'd7) state <= STOP;
        end
        STOP: if (stop_pt) begin
          if (maj_stop) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard bench for uart_rx_os at 160 clocks per bit
module tb_uart_rx_os;
  logic clk = 1'b0, reset = 1'b1, RXD = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, rx_busy;
  int tests = 0, fails = 0, n_valid = 0, n_ferr = 0;
  logic [7:0] sb[$];
  logic [7:0] last_data = 8'h00, exp_b;
  logic busy_at_valid = 1'b1;

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .RXD(RXD), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      busy_at_valid = rx_busy;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: rx_data=%h, no byte expected", rx_data);
      end else begin
        exp_b = sb.pop_front();
        if (rx_data !== exp_b) begin
          fails++;
          $display("FAIL sb_data: rx_data=%h expected %h", rx_data, exp_b);
        end
      end
      last_data = rx_data;
    end else if (rx_data !== last_data) begin
      fails++;
      $display("FAIL data_stable: rx_data=%h changed from %h without rx_valid", rx_data, last_data);
    end
    if (frame_err) n_ferr++;
    if (rx_valid && frame_err) begin
      fails++;
      $display("FAIL exclusive: rx_valid=1 and frame_err=1 together");
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int p, input int g, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < p; c++) begin
        RXD = (c == g) ? ~f[i] : f[i];
        @(posedge clk);
        #1;
      end
  endtask

  task automatic test_reset;
    logic bad;
    bad = 1'b0;
    RXD = 1'b1;
    reset = 1'b1;
    cyc(1);
    last_data = 8'h00;
    cyc(3);
    reset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0 || rx_data !== 8'h00) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: outputs not quiet (busy=%b valid=%b ferr=%b data=%h), expected 0/0/0/00",
               rx_busy, rx_valid, frame_err, rx_data);
    end
  endtask

  task automatic test_single;
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    sb.push_back(8'hA5);
    send(8'hA5, 160, -1, 1'b1);
    cyc(200);
    tests++;
    if (n_valid - v0 !== 1) begin fails++; $display("FAIL single_count: %0d pulses, expected 1", n_valid - v0); end
    tests++;
    if (rx_data !== 8'hA5) begin fails++; $display("FAIL single_data: %h, expected a5", rx_data); end
    tests++;
    if (busy_at_valid !== 1'b0) begin fails++; $display("FAIL single_busy: rx_busy=%b at rx_valid, expected 0", busy_at_valid); end
    tests++;
    if (n_ferr !== f0) begin fails++; $display("FAIL single_ferr: %0d frame errors, expected 0", n_ferr - f0); end
  endtask

  task automatic test_back_to_back;
    int v0;
    logic [7:0] bytes [3];
    bytes = '{8'h00, 8'hFF, 8'h3C};
    v0 = n_valid;
    foreach (bytes[i]) sb.push_back(bytes[i]);
    foreach (bytes[i]) send(bytes[i], 160, -1, 1'b1);
    cyc(200);
    tests++;
    if (n_valid - v0 !== 3) begin fails++; $display("FAIL b2b_count: %0d pulses, expected 3", n_valid - v0); end
    tests++;
    if (sb.size() !== 0) begin fails++; $display("FAIL b2b_pending: %0d bytes missing, expected 0", sb.size()); end
    tests++;
    if (rx_data !== 8'h3C) begin fails++; $display("FAIL b2b_last: %h, expected 3c", rx_data); end
  endtask

  task automatic test_false_start;
    int v0, f0, w;
    v0 = n_valid;
    f0 = n_ferr;
    RXD = 1'b0;
    cyc(20);
    tests++;
    if (rx_busy !== 1'b1) begin fails++; $display("FAIL fs_busy_hi: rx_busy=%b, expected 1", rx_busy); end
    cyc(20);
    RXD = 1'b1;
    w = 0;
    while (rx_busy === 1'b1 && w < 300) begin
      cyc(1);
      w++;
    end
    tests++;
    if (w < 110 || w > 140) begin fails++; $display("FAIL fs_busy_lo: rx_busy fell after %0d cycles, expected 110..140", w); end
    tests++;
    if (n_valid !== v0 || n_ferr !== f0) begin
      fails++;
      $display("FAIL fs_pulses: valid=%0d ferr=%0d, expected 0/0", n_valid - v0, n_ferr - f0);
    end
    sb.push_back(8'h55);
    send(8'h55, 160, -1, 1'b1);
    cyc(200);
    tests++;
    if (n_valid - v0 !== 1 || rx_data !== 8'h55) begin
      fails++;
      $display("FAIL fs_next: %0d pulses data=%h, expected 1 pulse data=55", n_valid - v0, rx_data);
    end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    send(8'h81, 160, -1, 1'b0);
    cyc(100);
    RXD = 1'b1;
    cyc(200);
    tests++;
    if (n_ferr - f0 !== 1) begin fails++; $display("FAIL fe_count: %0d frame errors, expected 1", n_ferr - f0); end
    tests++;
    if (n_valid !== v0) begin fails++; $display("FAIL fe_valid: %0d pulses, expected 0", n_valid - v0); end
    tests++;
    if (rx_data !== 8'h55) begin fails++; $display("FAIL fe_hold: rx_data=%h, expected 55", rx_data); end
    tests++;
    if (rx_busy !== 1'b0) begin fails++; $display("FAIL fe_idle: rx_busy=%b, expected 0", rx_busy); end
    sb.push_back(8'h42);
    send(8'h42, 160, -1, 1'b1);
    cyc(200);
    tests++;
    if (n_valid - v0 !== 1 || rx_data !== 8'h42) begin
      fails++;
      $display("FAIL fe_next: %0d pulses data=%h, expected 1 pulse data=42", n_valid - v0, rx_data);
    end
  endtask

  task automatic test_glitch;
    int periods [3];
    int v0;
    periods = '{160, 165, 155};
    foreach (periods[i]) begin
      v0 = n_valid;
      sb.push_back(8'h5A);
      send(8'h5A, periods[i], 80, 1'b1);
      cyc(200);
      tests++;
      if (n_valid - v0 !== 1 || rx_data !== 8'h5A) begin
        fails++;
        $display("FAIL glitch_p%0d: %0d pulses data=%h, expected 1 pulse data=5a", periods[i], n_valid - v0, rx_data);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] f;
    int v0, f0;
    f = {1'b1, 8'hC3, 1'b0};
    v0 = n_valid;
    f0 = n_ferr;
    for (int i = 0; i < 5; i++) begin
      RXD = f[i];
      cyc(160);
    end
    RXD = f[5];
    cyc(80);
    reset = 1'b1;
    cyc(1);
    last_data = 8'h00;
    reset = 1'b0;
    RXD = 1'b1;
    @(negedge clk);
    tests++;
    if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset: busy=%b data=%h, expected 0/00", rx_busy, rx_data);
    end
    @(posedge clk);
    #1;
    cyc(300);
    tests++;
    if (n_valid !== v0 || n_ferr !== f0) begin
      fails++;
      $display("FAIL mid_pulses: valid=%0d ferr=%0d, expected 0/0", n_valid - v0, n_ferr - f0);
    end
    sb.push_back(8'h96);
    send(8'h96, 160, -1, 1'b1);
    cyc(200);
    tests++;
    if (n_valid - v0 !== 1 || rx_data !== 8'h96) begin
      fails++;
      $display("FAIL mid_next: %0d pulses data=%h, expected 1 pulse data=96", n_valid - v0, rx_data);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    tests++;
    if (sb.size() !== 0) begin fails++; $display("FAIL sb_drain: %0d bytes never received", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
